// File: rtl/acc8_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : acc8_pkg
// Purpose  : Shared op codes, FSM state encoding and default width for the
//            acc8 accumulator stage.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package acc8_pkg;

  localparam int WIDTH_DEF = 8;

  // Operation codes carried on in_op
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ADC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : add8
// Purpose  : Ripple-carry adder. X = A + B + C, R = carry out of the MSB.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module add8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] X,
  output logic             R
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = C;

  // One full-adder cell per bit; the carry ripples from bit 0 upwards
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign X[i]     = A[i] ^ B[i] ^ w_c[i];
      assign w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
    end
  endgenerate

  assign R = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/acc8_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : acc8_unit
// Purpose  : Accumulator stage around a ripple adder. Operands arrive over a
//            valid/ready handshake; ADD/ADC hold the adder inputs stable for
//            SETTLE cycles before capturing sum and carry.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module acc8_unit
  import acc8_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = 2          // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [3:0] C_SETTLE_M1 = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nx;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_b_nx;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nx;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nx;
  logic             r_carry;
  logic             w_carry_nx;
  logic             r_zero;

  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_xfer;

  // Adder is driven purely from registers so its inputs stay still while it settles
  assign w_cin = (r_op == OP_ADC) ? r_carry : 1'b0;

  add8 #(.WIDTH(WIDTH)) u_add (
    .A (r_acc),
    .B (r_b),
    .C (w_cin),
    .X (w_sum),
    .R (w_cout)
  );

  // Ready is suppressed while reset is asserted, even before the first edge
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign w_xfer    = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign acc       = r_acc;
  assign carry     = r_carry;
  assign zero      = r_zero;

  // Next-state and datapath update selection
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_acc_nx   = r_acc;
    w_carry_nx = r_carry;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          case (in_op)
            OP_LOAD: begin
              w_acc_nx   = in_data;
              w_carry_nx = 1'b0;
              w_state_nx = S_DONE;
            end
            OP_CLR: begin
              w_acc_nx   = '0;
              w_carry_nx = 1'b0;
              w_state_nx = S_DONE;
            end
            default: begin
              w_b_nx     = in_data;
              w_op_nx    = in_op;
              w_cnt_nx   = C_SETTLE_M1;
              w_state_nx = S_WAIT;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          w_acc_nx   = w_sum;
          w_carry_nx = w_cout;
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; zero tracks the value being written to acc
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_b     <= '0;
      r_op    <= OP_LOAD;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
      r_acc   <= w_acc_nx;
      r_carry <= w_carry_nx;
      r_zero  <= (w_acc_nx == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc8_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_acc8_unit
// Purpose  : Directed, table-driven self-checking bench for acc8_unit.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_acc8_unit;

  localparam logic [1:0] T_LOAD = 2'b00;
  localparam logic [1:0] T_ADD  = 2'b01;
  localparam logic [1:0] T_ADC  = 2'b10;
  localparam logic [1:0] T_CLR  = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic [7:0] acc;
  logic       carry;
  logic       zero;
  logic       out_valid;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] acc;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t v[12];

  acc8_unit #(.WIDTH(8), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .acc       (acc),
    .carry     (carry),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one op, wait for completion, check latency, result and pulse width
  task automatic do_op(input string name, input logic [1:0] op, input logic [7:0] data,
                       input logic [7:0] e_acc, input logic e_c, input logic e_z, input int e_lat);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({name, "_lat"},   32'(lat),   32'(e_lat));
    chk({name, "_acc"},   32'(acc),   32'(e_acc));
    chk({name, "_carry"}, 32'(carry), 32'(e_c));
    chk({name, "_zero"},  32'(zero),  32'(e_z));
    @(negedge clk);
    chk({name, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int ov_seen;
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_op    = T_ADD;
    in_data  = 8'h5A;

    // op, data, expected acc, carry, zero, latency
    v[0]  = '{T_LOAD, 8'hD0, 8'hD0, 1'b0, 1'b0, 1};
    v[1]  = '{T_ADD,  8'h3F, 8'h0F, 1'b1, 1'b0, 3};
    v[2]  = '{T_ADC,  8'h00, 8'h10, 1'b0, 1'b0, 3};
    v[3]  = '{T_ADC,  8'hF0, 8'h00, 1'b1, 1'b1, 3};
    v[4]  = '{T_LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0, 1};
    v[5]  = '{T_ADD,  8'h01, 8'h00, 1'b1, 1'b1, 3};
    v[6]  = '{T_CLR,  8'h77, 8'h00, 1'b0, 1'b1, 1};
    v[7]  = '{T_LOAD, 8'hFF, 8'hFF, 1'b0, 1'b0, 1};
    v[8]  = '{T_ADD,  8'hFF, 8'hFE, 1'b1, 1'b0, 3};
    v[9]  = '{T_ADC,  8'hFF, 8'hFE, 1'b1, 1'b0, 3};
    v[10] = '{T_ADD,  8'h00, 8'hFE, 1'b0, 1'b0, 3};
    v[11] = '{T_LOAD, 8'h00, 8'h00, 1'b0, 1'b1, 1};

    // Reset held three cycles with in_valid asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acc",       32'(acc),       32'h00);
    chk("rst_carry",     32'(carry),     32'd0);
    chk("rst_zero",      32'(zero),      32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Table-driven sequence; each row builds on the previous accumulator
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), v[i].op, v[i].data, v[i].acc, v[i].c, v[i].z, v[i].lat);
    end

    // Busy interaction: inputs wiggle during WAIT and must be ignored
    do_op("busy_load", T_LOAD, 8'h10, 8'h10, 1'b0, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = T_ADD;
    in_data  = 8'h05;
    @(posedge clk);
    #1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      in_op    = T_LOAD;
      in_data  = 8'hAA;
    end
    in_valid = 1'b0;
    chk("busy_lat", 32'(lat), 32'd3);
    chk("busy_acc", 32'(acc), 32'h15);
    @(negedge clk);
    chk("busy_after_acc", 32'(acc), 32'h15);

    // in_valid held high: LOAD accepted on every IDLE cycle, one result per 2 cycles
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = T_LOAD;
    in_data  = 8'h01;
    @(posedge clk);
    #1;
    ov_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
      chk($sformatf("held_ov%0d", k), 32'(out_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    chk("held_count", 32'(ov_seen), 32'd3);
    chk("held_acc",   32'(acc),     32'h01);

    // Reset during WAIT aborts the ADD without a result pulse
    do_op("mid_load", T_LOAD, 8'h44, 8'h44, 1'b0, 1'b0, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = T_ADD;
    in_data  = 8'h11;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_ov", 32'(ov_seen),  32'd0);
    chk("midrst_acc",   32'(acc),      32'h00);
    chk("midrst_carry", 32'(carry),    32'd0);
    chk("midrst_zero",  32'(zero),     32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    do_op("post_load", T_LOAD, 8'h33, 8'h33, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
